// File: rtl/viterbi_decode_if.sv
// Symbol-in / decision-out signal bundle for the K=3 Viterbi decoder.
// The master drives received symbols; the slave (decoder) returns registered decisions.
interface viterbi_decode_if;
    logic       en_p;
    logic [1:0] code_sig;
    logic       decode_sig;
    logic       valid_sig;

    modport master (
        output en_p,
        output code_sig,
        input  decode_sig,
        input  valid_sig
    );

    modport slave (
        input  en_p,
        input  code_sig,
        output decode_sig,
        output valid_sig
    );
endinterface

// File: rtl/viterbi_decode.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) code.
// Register-exchange survivors, per-symbol metric normalisation, registered outputs.
module viterbi_decode #(
    parameter int TRACE_DEPTH = 15,
    parameter int PM_WIDTH    = 6
) (
    input logic             clk_sig,
    input logic             rst_n,
    viterbi_decode_if.slave bus
);
    localparam int CW = $clog2(TRACE_DEPTH);

    typedef logic [PM_WIDTH-1:0]    pm_t;
    typedef logic [PM_WIDTH:0]      sum_t;
    typedef logic [TRACE_DEPTH-1:0] surv_t;

    pm_t           metric     [4];
    pm_t           metric_nxt [4];
    surv_t         surv       [4];
    surv_t         surv_nxt   [4];
    sum_t          acc        [4];
    sum_t          min_acc;
    logic [1:0]    out_state;
    logic [CW-1:0] cnt;

    function automatic sum_t hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return sum_t'(d[1]) + sum_t'(d[0]);
    endfunction

    // Next state n={u,s1} is reached from {s1,0} and {s1,1}; their expected pairs are complements.
    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam int U      = n / 2;
        localparam int S1     = n % 2;
        localparam int P_LO   = 2 * S1;
        localparam int P_HI   = P_LO + 1;
        localparam int EXP_LO = ((U ^ S1) << 1) | U;
        localparam int EXP_HI = EXP_LO ^ 3;

        sum_t sum_lo;
        sum_t sum_hi;
        logic take_hi;

        assign sum_lo  = sum_t'(metric[P_LO]) + hamming(bus.code_sig, 2'(EXP_LO));
        assign sum_hi  = sum_t'(metric[P_HI]) + hamming(bus.code_sig, 2'(EXP_HI));
        // Strict compare so equal sums keep the {s1,0} predecessor.
        assign take_hi = (sum_hi < sum_lo);
        assign acc[n]  = take_hi ? sum_hi : sum_lo;

        assign surv_nxt[n]   = {take_hi ? surv[P_HI][TRACE_DEPTH-2:0]
                                        : surv[P_LO][TRACE_DEPTH-2:0], 1'(U)};
        assign metric_nxt[n] = pm_t'(acc[n] - min_acc);
    end

    // NOTE: both outputs get a value before the loop, so no latch can be inferred.
    always_comb begin
        min_acc   = acc[0];
        out_state = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (acc[n] < min_acc) begin
                min_acc   = acc[n];
                out_state = 2'(n);
            end
        end
    end

    // NOTE: survivors are reset too: decisions are read from bit TRACE_DEPTH-1 before it has been filled.
    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) begin
                metric[s] <= (s == 0) ? pm_t'(0) : pm_t'(8);
                surv[s]   <= '0;
            end
            cnt            <= '0;
            bus.decode_sig <= 1'b0;
            bus.valid_sig  <= 1'b0;
        end else if (bus.en_p) begin
            for (int s = 0; s < 4; s++) begin
                metric[s] <= metric_nxt[s];
                surv[s]   <= surv_nxt[s];
            end
            if (cnt != CW'(TRACE_DEPTH - 1)) begin
                cnt <= cnt + CW'(1);
            end
            bus.decode_sig <= surv_nxt[out_state][TRACE_DEPTH-1];
            bus.valid_sig  <= (cnt == CW'(TRACE_DEPTH - 1));
        end else begin
            bus.valid_sig <= 1'b0;
        end
    end
endmodule

// File: tb/tb_viterbi_decode.sv
// Self-checking bench for viterbi_decode: a full-history Viterbi model with unnormalised
// integer metrics is compared against the DUT on every falling clock edge.
module tb_viterbi_decode;
    localparam int TD = 15;

    logic clk_sig = 1'b0;
    logic rst_n;

    viterbi_decode_if bus ();

    viterbi_decode #(.TRACE_DEPTH(TD), .PM_WIDTH(6)) dut (
        .clk_sig (clk_sig),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sig = ~clk_sig;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         pm   [4];
    bit         hist [4][$];
    int         acc_cnt;
    int         first_valid;
    logic       exp_decode;
    logic       exp_valid;
    bit         dut_bits[$];
    bit         model_bits[$];
    logic [1:0] stim_q[$];
    bit         info_q[$];
    bit         run_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [1:0] enc(input int s, input int u);
        int s1;
        int s0;
        s1 = (s >> 1) & 1;
        s0 = s & 1;
        return {1'(u ^ s1 ^ s0), 1'(u ^ s0)};
    endfunction

    function automatic int ham(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return int'(d[0]) + int'(d[1]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            pm[s] = (s == 0) ? 0 : 8;
            hist[s].delete();
        end
        acc_cnt     = 0;
        first_valid = -1;
        exp_decode  = 1'b0;
        exp_valid   = 1'b0;
        dut_bits.delete();
        model_bits.delete();
    endtask

    // Forward trellis step over every (state, input) branch; whole paths are kept, never truncated.
    task automatic model_step(input logic [1:0] code);
        int best_pm [4];
        int src     [4];
        int win;
        bit nh      [4][$];
        for (int n = 0; n < 4; n++) begin
            best_pm[n] = 1 << 30;
            src[n]     = 0;
        end
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                int n;
                int cand;
                n    = (u << 1) | ((s >> 1) & 1);
                cand = pm[s] + ham(code, enc(s, u));
                if (cand < best_pm[n]) begin
                    best_pm[n] = cand;
                    src[n]     = s;
                end
            end
        end
        win = 0;
        for (int n = 1; n < 4; n++) begin
            if (best_pm[n] < best_pm[win]) win = n;
        end
        for (int n = 0; n < 4; n++) begin
            nh[n] = hist[src[n]];
            nh[n].push_back(bit'(n >> 1));
        end
        for (int n = 0; n < 4; n++) begin
            pm[n]   = best_pm[n];
            hist[n] = nh[n];
        end
        if (acc_cnt >= TD - 1) begin
            exp_decode = hist[win][acc_cnt-(TD-1)];
            exp_valid  = 1'b1;
            model_bits.push_back(exp_decode);
        end else begin
            exp_decode = 1'b0;
            exp_valid  = 1'b0;
        end
        acc_cnt++;
    endtask

    task automatic step(input logic en, input logic [1:0] code);
        @(negedge clk_sig);
        bus.en_p     = en;
        bus.code_sig = code;
        @(posedge clk_sig);
        if (en && rst_n) model_step(code);
        else exp_valid = 1'b0;
    endtask

    always @(negedge clk_sig) begin
        if (run_chk) begin
            check("decode_sig", bus.decode_sig, exp_decode);
            check("valid_sig", bus.valid_sig, exp_valid);
            if (bus.valid_sig === 1'b1) begin
                dut_bits.push_back(bus.decode_sig);
                if (first_valid < 0) first_valid = acc_cnt;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk_sig);
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_sig);
        @(posedge clk_sig);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input int gap_lo, input int gap_hi);
        foreach (stim_q[i]) begin
            step(1'b1, stim_q[i]);
            repeat ($urandom_range(gap_hi, gap_lo)) step(1'b0, 2'($urandom));
        end
        step(1'b0, 2'b00);
    endtask

    task automatic build_known();
        logic [1:0] head [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        stim_q.delete();
        foreach (head[i]) stim_q.push_back(head[i]);
        repeat (20) stim_q.push_back(2'b00);
    endtask

    task automatic check_known(input string tag);
        bit ref_bits [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        check({tag, "_count"}, dut_bits.size(), stim_q.size() - (TD - 1));
        check({tag, "_first_valid"}, first_valid, TD);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_dut_bit%0d", tag, i), dut_bits[i], ref_bits[i]);
            check($sformatf("%s_model_bit%0d", tag, i), model_bits[i], ref_bits[i]);
        end
        for (int i = 6; i < dut_bits.size(); i++) begin
            check($sformatf("%s_tail_bit%0d", tag, i), dut_bits[i], 0);
        end
    endtask

    initial begin
        int ones;
        rst_n        = 1'b0;
        bus.en_p     = 1'b0;
        bus.code_sig = 2'b00;
        model_reset();
        run_chk = 1'b1;

        // Reset held: enable activity must not disturb anything.
        for (int i = 0; i < 6; i++) step(1'(i % 2), 2'b11);
        check("rst_decode", bus.decode_sig, 0);
        check("rst_valid", bus.valid_sig, 0);
        @(posedge clk_sig);
        #2;
        rst_n = 1'b1;
        repeat (20) step(1'b0, 2'($urandom));
        check("idle_valid_count", dut_bits.size(), 0);

        // All-zero stream.
        do_reset();
        stim_q.delete();
        repeat (40) stim_q.push_back(2'b00);
        run_stream(0, 0);
        check("zero_first_valid", first_valid, TD);
        check("zero_count", dut_bits.size(), 40 - (TD - 1));
        ones = 0;
        foreach (dut_bits[i]) ones += int'(dut_bits[i]);
        check("zero_ones", ones, 0);

        // Known stream, clean.
        do_reset();
        build_known();
        run_stream(0, 0);
        check_known("clean");

        // Known stream with one bit error in symbol 3.
        do_reset();
        build_known();
        stim_q[3] = 2'b11;
        run_stream(0, 0);
        check_known("err");

        // Known stream with three idle cycles between symbols.
        do_reset();
        build_known();
        run_stream(3, 3);
        check_known("gap");

        // Asynchronous reset mid-stream, then restart.
        do_reset();
        build_known();
        for (int i = 0; i < TD; i++) step(1'b1, stim_q[i]);
        #1;
        check("pre_rst_valid", bus.valid_sig, 1);
        check("pre_rst_decode", bus.decode_sig, 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", bus.valid_sig, 0);
        check("async_rst_decode", bus.decode_sig, 0);
        @(posedge clk_sig);
        #2;
        rst_n = 1'b1;
        run_stream(0, 0);
        check_known("restart");

        // Random streams: the first two error-free, the rest with sparse bit errors.
        for (int t = 0; t < 4; t++) begin
            int s;
            do_reset();
            stim_q.delete();
            info_q.delete();
            s = 0;
            for (int i = 0; i < 74; i++) begin
                bit         u;
                logic [1:0] c;
                u = (i < 60) ? bit'($urandom_range(1, 0)) : 1'b0;
                c = enc(s, int'(u));
                if (t >= 2 && $urandom_range(29, 0) == 0) c = c ^ 2'(1 << $urandom_range(1, 0));
                info_q.push_back(u);
                stim_q.push_back(c);
                s = (int'(u) << 1) | ((s >> 1) & 1);
            end
            run_stream(0, 2);
            check($sformatf("rand%0d_count", t), dut_bits.size(), stim_q.size() - (TD - 1));
            if (t < 2) begin
                for (int i = 0; i < dut_bits.size(); i++) begin
                    check($sformatf("rand%0d_info_bit%0d", t, i), dut_bits[i], info_q[i]);
                end
            end
        end

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/viterbi_decode.md
VITERBI_DECODE -- requirements
Module: viterbi_decode

Interface
REQ-001 SHALL have parameter TRACE_DEPTH, default 15, giving survivor length in symbols (legal 5..31).
REQ-002 SHALL have parameter PM_WIDTH, default 6, giving path-metric width in bits (legal >= 5).
REQ-003 SHALL have port clk_sig  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_p  input  1  high: code_sig holds a valid symbol this cycle.
REQ-006 SHALL have port code_sig  input  2  received hard-decision symbol pair {c1,c0}.
REQ-007 SHALL have port decode_sig  output  1  decoded information bit, registered.
REQ-008 SHALL have port valid_sig  output  1  high for one cycle per accepted symbol once decode_sig carries a decision.

Function
REQ-009 SHALL decode a rate-1/2, K=3 code: state s={s1,s0} (previous two info bits); for input u, c1=u^s1^s0 (G=7 octal), c0=u^s0 (G=5 octal); next state {u,s1}.
REQ-010 SHALL accept a symbol only on a rising edge with en_p=1; with en_p=0, metrics, survivors, counter and decode_sig hold and valid_sig=0.
REQ-011 SHALL compute branch metric as Hamming distance (0..2) between code_sig and each branch's expected pair.
REQ-012 SHALL perform add-compare-select per next state over its two predecessors {s1,0} and {s1,1}; on equal sums select predecessor {s1,0}.
REQ-013 SHALL normalise each cycle by subtracting the minimum of the four new metrics, so the minimum stored metric is always 0 and no metric ever wraps.
REQ-014 SHALL keep one TRACE_DEPTH-bit survivor per state (register exchange): new survivor = {selected predecessor survivor[TRACE_DEPTH-2:0], u}.
REQ-015 SHALL choose the output state as the lowest-index state with minimum new metric.
REQ-016 SHALL register decode_sig <= output-state new survivor[TRACE_DEPTH-1] on each accepted symbol; this is the decision for the symbol accepted TRACE_DEPTH-1 acceptances earlier.
REQ-017 SHALL keep a saturating accept counter; valid_sig SHALL be 1 on the cycle after acceptance number TRACE_DEPTH onward, for each accepted symbol only.
REQ-018 SHALL make decode_sig and valid_sig change only on clock edges (no combinational path from inputs).

Reset
REQ-019 SHALL, while rst_n=0, set metric[0]=0, metric[1..3]=8, all survivors 0, counter 0, decode_sig=0, valid_sig=0.
REQ-020 SHALL, on rst_n deasserting, start decoding from the encoder zero state with the first accepted symbol as symbol 0.
REQ-021 SHALL, on rst_n asserted mid-stream, discard all history immediately regardless of clk_sig.

Verification
REQ-022 SHALL pass: hold rst_n=0 -> decode_sig=0, valid_sig=0; release, en_p=0 for 20 cycles -> outputs stay 0.
REQ-023 SHALL pass: en_p=1, code_sig=00 for 40 symbols -> valid_sig first high after symbol 15, decode_sig=0 throughout.
REQ-024 SHALL pass: symbols 11,10,00,01,01,11 then 00 x20 -> decoded bits 1,0,1,1,0,0,0... with decisions emerging 14 acceptances after their symbol.
REQ-025 SHALL pass: same stream with symbol 3 flipped to 11 (one bit error) -> identical decoded bits.
REQ-026 SHALL pass: same stream with en_p=0 for 3 cycles between each symbol -> identical decoded bits; valid_sig never high while en_p=0.
REQ-027 SHALL pass: rst_n pulsed low mid-stream -> outputs 0 asynchronously; restarted stream decodes correctly, valid_sig again after 15 acceptances.
